// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: round-robin EXU/LSU writeback arbiter with per-register pending scoreboard.
// Define RF_WB_FORWARD_EN to add same-cycle forwarding of the registered RF write to the read ports.
module rf_wb_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [ADDR_WIDTH-1:0] exu_addr,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  output logic                  iss_ready,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  input  logic [ADDR_WIDTH-1:0] raddr1,
  input  logic [ADDR_WIDTH-1:0] raddr2,
  output logic                  hazard1,
  output logic                  hazard2
`ifdef RF_WB_FORWARD_EN
  ,
  output logic                  fwd1_en,
  output logic                  fwd2_en,
  output logic [DATA_WIDTH-1:0] fwd1_data,
  output logic [DATA_WIDTH-1:0] fwd2_data
`endif
);
  localparam int NREGS = 1 << ADDR_WIDTH;
  logic                  prio;
  logic [NREGS-1:0]      pending, set_mask, clr_mask;
  logic                  wb_go, iss_go, fwd1, fwd2;
  logic [ADDR_WIDTH-1:0] wb_addr;
  logic [DATA_WIDTH-1:0] wb_data;
  // prio=0 favours EXU, prio=1 favours LSU when both request
  assign exu_ready = rst && exu_valid && (!lsu_valid || !prio);
  assign lsu_ready = rst && lsu_valid && (!exu_valid || prio);
  assign wb_go     = exu_ready || lsu_ready;
  assign wb_addr   = lsu_ready ? lsu_addr : exu_addr;
  assign wb_data   = lsu_ready ? lsu_data : exu_data;
  assign iss_ready = rst && (iss_rd == '0 || !pending[iss_rd]);
  assign iss_go    = iss_valid && iss_ready && iss_rd != '0;
  assign set_mask  = iss_go ? NREGS'(1) << iss_rd : '0;
  assign clr_mask  = rf_wen ? NREGS'(1) << rf_waddr : '0;
  always_ff @(posedge clk) begin
    if (!rst) begin
      prio     <= 1'b0;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      pending  <= '0;
    end else begin
      if (wb_go) begin
        prio     <= exu_ready;
        rf_waddr <= wb_addr;
        rf_wdata <= wb_data;
      end
      rf_wen  <= wb_go && wb_addr != '0;
      pending <= ((pending & ~clr_mask) | set_mask) & ~NREGS'(1);
    end
  end
`ifdef RF_WB_FORWARD_EN
  assign fwd1      = rf_wen && raddr1 == rf_waddr && raddr1 != '0;
  assign fwd2      = rf_wen && raddr2 == rf_waddr && raddr2 != '0;
  assign fwd1_en   = fwd1;
  assign fwd2_en   = fwd2;
  assign fwd1_data = fwd1 ? rf_wdata : '0;
  assign fwd2_data = fwd2 ? rf_wdata : '0;
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif
  assign hazard1 = pending[raddr1] && !fwd1;
  assign hazard2 = pending[raddr2] && !fwd2;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: directed scenarios plus random traffic checked every cycle against a behavioural model.
module tb_rf_wb_arbiter;
  logic clk = 1'b0;
  logic rst, exu_valid, lsu_valid, iss_valid, exu_ready, lsu_ready, iss_ready;
  logic rf_wen, hazard1, hazard2;
  logic [3:0] exu_addr, lsu_addr, iss_rd, rf_waddr, raddr1, raddr2;
  logic [31:0] exu_data, lsu_data, rf_wdata;
  logic fwd1_en, fwd2_en;
  logic [31:0] fwd1_data, fwd2_data;
  int total = 0, bad = 0;
  bit chk_en = 1'b0;
  bit fwd_build;
  // behavioural model state
  bit m_turn_lsu = 0, m_wen = 0, m_zero = 1;
  bit [3:0] m_waddr = 0;
  bit [31:0] m_wdata = 0;
  bit m_pend [16];
  int win;
  bit e_iss, e_f1, e_f2;

  always #5 clk = ~clk;

  rf_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_addr(exu_addr), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_addr(lsu_addr), .lsu_data(lsu_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .raddr1(raddr1), .raddr2(raddr2), .hazard1(hazard1), .hazard2(hazard2)
`ifdef RF_WB_FORWARD_EN
    , .fwd1_en(fwd1_en), .fwd2_en(fwd2_en), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data)
`endif
  );
`ifndef RF_WB_FORWARD_EN
  assign fwd1_en = 1'b0;
  assign fwd2_en = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_data = '0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // compare + model advance; inputs are stable from posedge+1 until the next posedge
  always @(negedge clk) begin
    if (!rst) win = 0;
    else if (exu_valid && lsu_valid) win = m_turn_lsu ? 2 : 1;
    else if (exu_valid) win = 1;
    else if (lsu_valid) win = 2;
    else win = 0;
    e_iss = rst && (iss_rd == 0 || !m_pend[iss_rd]);
    e_f1 = fwd_build && m_wen && raddr1 == m_waddr && raddr1 != 0;
    e_f2 = fwd_build && m_wen && raddr2 == m_waddr && raddr2 != 0;
    if (chk_en) begin
      chk("m_exu_ready", exu_ready, win == 1);
      chk("m_lsu_ready", lsu_ready, win == 2);
      chk("m_iss_ready", iss_ready, e_iss);
      chk("m_rf_wen", rf_wen, m_wen);
      if (m_wen || m_zero) begin
        chk("m_rf_waddr", rf_waddr, m_waddr);
        chk("m_rf_wdata", rf_wdata, m_wdata);
      end
      chk("m_hazard1", hazard1, m_pend[raddr1] && !e_f1);
      chk("m_hazard2", hazard2, m_pend[raddr2] && !e_f2);
      chk("m_fwd1_en", fwd1_en, e_f1);
      chk("m_fwd2_en", fwd2_en, e_f2);
      chk("m_fwd1_data", fwd1_data, e_f1 ? m_wdata : 0);
      chk("m_fwd2_data", fwd2_data, e_f2 ? m_wdata : 0);
    end
    if (!rst) begin
      m_turn_lsu = 0; m_wen = 0; m_waddr = 0; m_wdata = 0; m_zero = 1;
      foreach (m_pend[i]) m_pend[i] = 0;
    end else begin
      if (m_wen) m_pend[m_waddr] = 0;
      if (iss_valid && e_iss && iss_rd != 0) m_pend[iss_rd] = 1;
      m_zero = 0;
      if (win != 0) begin
        m_turn_lsu = (win == 1);
        m_waddr = (win == 1) ? exu_addr : lsu_addr;
        m_wdata = (win == 1) ? exu_data : lsu_data;
        m_wen = m_waddr != 0;
      end else m_wen = 0;
    end
  end

  initial begin
`ifdef RF_WB_FORWARD_EN
    fwd_build = 1;
`else
    fwd_build = 0;
`endif
    rst = 0; exu_valid = 0; lsu_valid = 0; iss_valid = 0;
    exu_addr = 0; lsu_addr = 0; iss_rd = 0; raddr1 = 0; raddr2 = 0;
    exu_data = 0; lsu_data = 0;
    cyc();
    chk_en = 1;
    exu_valid = 1; lsu_valid = 1; iss_valid = 1; iss_rd = 3;
    #1;
    chk("rst_rf_wen", rf_wen, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_exu_ready", exu_ready, 0);
    chk("rst_lsu_ready", lsu_ready, 0);
    chk("rst_iss_ready", iss_ready, 0);
    cyc();
    exu_valid = 0; lsu_valid = 0; iss_valid = 0; rst = 1;
    // both requesters for 4 cycles: EXU,LSU,EXU,LSU
    for (int i = 0; i < 4; i++) begin
      cyc();
      exu_valid = 1; lsu_valid = 1;
      exu_addr = 4'(1 + i); exu_data = 32'h100 + i;
      lsu_addr = 4'(8 + i); lsu_data = 32'h800 + i;
      #1;
      chk("rr_exu_ready", exu_ready, (i % 2) == 0);
      chk("rr_lsu_ready", lsu_ready, (i % 2) == 1);
      if (i > 0) begin
        chk("rr_wen", rf_wen, 1);
        chk("rr_waddr", rf_waddr, (i % 2) == 1 ? i : 8 + i - 1);
      end
    end
    cyc();
    exu_valid = 0; lsu_valid = 0;
    #1;
    chk("rr_last_waddr", rf_waddr, 11);
    chk("rr_last_wdata", rf_wdata, 32'h803);
    // single EXU write to a5
    cyc();
    exu_valid = 1; exu_addr = 15; exu_data = 32'h12345678;
    #1;
    chk("a5_ready", exu_ready, 1);
    chk("a5_wen_before", rf_wen, 0);
    cyc();
    exu_valid = 0;
    #1;
    chk("a5_wen", rf_wen, 1);
    chk("a5_waddr", rf_waddr, 15);
    chk("a5_wdata", rf_wdata, 32'h12345678);
    cyc();
    #1;
    chk("a5_wen_after", rf_wen, 0);
    // WAW stall on a0
    cyc();
    iss_valid = 1; iss_rd = 10; raddr1 = 10;
    #1;
    chk("waw_first_ready", iss_ready, 1);
    chk("waw_first_haz", hazard1, 0);
    cyc();
    #1;
    chk("waw_stall", iss_ready, 0);
    chk("waw_haz", hazard1, 1);
    cyc();
    exu_valid = 1; exu_addr = 10; exu_data = 32'hA0A0A0A0;
    #1;
    chk("waw_wb_ready", exu_ready, 1);
    chk("waw_stall2", iss_ready, 0);
    cyc();
    exu_valid = 0;
    #1;
    chk("waw_rf_wen", rf_wen, 1);
    chk("waw_stall3", iss_ready, 0);
    chk("waw_haz_wb", hazard1, fwd_build ? 0 : 1);
    cyc();
    #1;
    chk("waw_release", iss_ready, 1);
    chk("waw_haz_clear", hazard1, 0);
    cyc();
    iss_valid = 0;
    #1;
    chk("waw_reissued", hazard1, 1);
    cyc();
    exu_valid = 1; exu_addr = 10;
    cyc();
    exu_valid = 0;
    cyc();
    // issue rd=5 while RF writes 5: set wins
    cyc();
    exu_valid = 1; exu_addr = 5; exu_data = 32'h55;
    cyc();
    exu_valid = 0; iss_valid = 1; iss_rd = 5; raddr2 = 5;
    #1;
    chk("sc_wen", rf_wen, 1);
    chk("sc_waddr", rf_waddr, 5);
    chk("sc_iss_ready", iss_ready, 1);
    cyc();
    iss_valid = 0;
    #1;
    chk("sc_haz", hazard2, 1);
    chk("sc_iss_stall", iss_ready, 0);
    // LSU write to x0
    cyc();
    lsu_valid = 1; lsu_addr = 0; lsu_data = 32'hFFFFFFFF; raddr1 = 0; iss_rd = 0;
    #1;
    chk("x0_ready", lsu_ready, 1);
    chk("x0_haz", hazard1, 0);
    chk("x0_iss_ready", iss_ready, 1);
    cyc();
    lsu_valid = 0;
    #1;
    chk("x0_no_wen", rf_wen, 0);
    // RF write to t0 with reset asserted in that cycle
    cyc();
    exu_valid = 1; exu_addr = 5; exu_data = 32'hDEADBEEF;
    cyc();
    exu_valid = 1; exu_addr = 7; rst = 0; raddr2 = 5;
    #1;
    chk("t0_wen", rf_wen, 1);
    chk("t0_wdata", rf_wdata, 32'hDEADBEEF);
    chk("t0_fwd2_en", fwd2_en, fwd_build);
    chk("t0_fwd2_data", fwd2_data, fwd_build ? 32'hDEADBEEF : 0);
    chk("t0_haz2", hazard2, fwd_build ? 0 : 1);
    chk("t0_rst_ready", exu_ready, 0);
    cyc();
    rst = 1; exu_valid = 0;
    #1;
    chk("t0_discard", rf_wen, 0);
    chk("t0_pend_clear", hazard2, 0);
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      cyc();
      rst = $urandom_range(0, 99) != 0;
      exu_valid = $urandom_range(0, 1); lsu_valid = $urandom_range(0, 2) != 0;
      iss_valid = $urandom_range(0, 1);
      exu_addr = 4'($urandom_range(0, 15)); lsu_addr = 4'($urandom_range(0, 15));
      iss_rd = 4'($urandom_range(0, 15));
      raddr1 = 4'($urandom_range(0, 15)); raddr2 = 4'($urandom_range(0, 15));
      exu_data = $urandom; lsu_data = $urandom;
    end
    cyc();
    rst = 1; exu_valid = 0; lsu_valid = 0; iss_valid = 0;
    repeat (3) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, meaning register index width (16 regs, RV32E).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning register data width.
REQ-003 SHALL have: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have: rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-005 SHALL have: exu_valid/exu_ready  in/out  1/1  EXU writeback handshake; exu_addr  in  ADDR_WIDTH; exu_data  in  DATA_WIDTH.
REQ-006 SHALL have: lsu_valid/lsu_ready  in/out  1/1  LSU writeback handshake; lsu_addr  in  ADDR_WIDTH; lsu_data  in  DATA_WIDTH.
REQ-007 SHALL have: iss_valid  in  1, iss_rd  in  ADDR_WIDTH, iss_ready  out  1  issue-side destination reservation.
REQ-008 SHALL have: rf_wen  out  1, rf_waddr  out  ADDR_WIDTH, rf_wdata  out  DATA_WIDTH  register-file write port drive.
REQ-009 SHALL have: raddr1, raddr2  in  ADDR_WIDTH; hazard1, hazard2  out  1  pending-producer flags for read ports.
REQ-010 SHALL have (FWD build only): fwd1_en, fwd2_en  out  1; fwd1_data, fwd2_data  out  DATA_WIDTH.

Function
REQ-011 SHALL accept at most one writeback per cycle; transfer occurs when valid && ready on a requester.
REQ-012 SHALL grant combinationally: only one valid -> that one ready; both valid -> requester indicated by prio flop ready, other not.
REQ-013 SHALL update prio on every grant to point at the non-granted requester (round-robin); no grant -> prio holds.
REQ-014 SHALL register the granted write: transfer in cycle N -> rf_wen=1, rf_waddr, rf_wdata driven in cycle N+1 only (latency 1).
REQ-015 SHALL keep rf_wen=0 in any cycle following a cycle with no transfer.
REQ-016 SHALL accept writebacks to address 0 (ready as normal) but never assert rf_wen for them.
REQ-017 SHALL hold a pending bit per register; bit 0 constant 0.
REQ-018 SHALL assert iss_ready = (iss_rd==0) || !pending[iss_rd]; WAW to a pending register stalls.
REQ-019 SHALL set pending[iss_rd] at edge ending a cycle with iss_valid && iss_ready && iss_rd!=0.
REQ-020 SHALL clear pending[rf_waddr] at edge ending a cycle with rf_wen=1.
REQ-021 SHALL give set priority over clear when both target the same register in one cycle.
REQ-022 SHALL drive hazardK = pending[raddrK] combinationally (K=1,2); raddrK==0 -> 0.
REQ-023 SHALL not check writeback address against pending; writeback to non-pending register still writes RF.

Reset
REQ-024 SHALL, when rst=0 at a rising edge: rf_wen=0, rf_waddr=0, rf_wdata=0, all pending=0, prio=EXU.
REQ-025 SHALL drive exu_ready, lsu_ready, iss_ready = 0 while rst=0.
REQ-026 SHALL discard an in-flight registered write on reset mid-operation: rf_wen=0 in the cycle after reset edge.

Configuration
REQ-027 SHALL compile forwarding logic and REQ-010 ports only when RF_WB_FORWARD_EN is defined.
REQ-028 SHALL, with RF_WB_FORWARD_EN: rf_wen=1 && raddrK==rf_waddr && raddrK!=0 -> fwdK_en=1, fwdK_data=rf_wdata, hazardK=0; else fwdK_en=0, fwdK_data=0.
REQ-029 SHALL, without RF_WB_FORWARD_EN: hazardK per REQ-022 only; consumer waits one extra cycle for RF write.

Verification
REQ-030 SHALL cover: reset release, single exu write a5=0x12345678 -> next cycle rf_wen=1, rf_waddr=15, rf_wdata=0x12345678, then rf_wen=0.
REQ-031 SHALL cover: exu and lsu valid for 4 consecutive cycles -> grants EXU,LSU,EXU,LSU; RF writes follow one cycle later in same order.
REQ-032 SHALL cover: issue rd=10, then iss_rd=10 again -> iss_ready=0 and hazard1=1 for raddr1=10 until cycle after rf_wen for a0.
REQ-033 SHALL cover: issue rd=5 same cycle rf_wen writes waddr=5 -> pending[5]=1 afterwards, hazard on raddr=5 stays 1.
REQ-034 SHALL cover: lsu write addr 0 data 0xFFFFFFFF -> lsu_ready=1, rf_wen stays 0, hazard for raddr 0 =0.
REQ-035 SHALL cover: FWD build, rf_wen writing t0=0xDEADBEEF while raddr2=5 -> fwd2_en=1, fwd2_data=0xDEADBEEF, hazard2=0; reset asserted during that cycle -> next cycle rf_wen=0.
